// File: rtl/axi_write_buffer.sv
// Write-back line buffer in front of the AXI master: queues cache line writebacks, drains them as
// 4-beat write bursts, and answers word reads from buffered lines or with a single-beat AXI read.
module axi_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [LINE_W-1:0] wb_data,
    input  logic              rd_req,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic [2:0]        count,
    output logic              empty,
    output logic              full,
    output logic              write,
    output logic [ADDR_W-1:0] addr_wr,
    output logic [LINE_W-1:0] data_wr,
    output logic [2:0]        w_burst,
    input  logic              done,
    output logic              read,
    output logic [ADDR_W-1:0] addr_rd,
    output logic [2:0]        r_burst,
    input  logic              done_r,
    input  logic [31:0]       data_rd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LA_W  = ADDR_W - 4;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP} state_t;

    state_t            state;
    logic [LA_W-1:0]   line_addr [DEPTH];
    logic [LINE_W-1:0] line_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic              push;
    logic              pop;
    logic              rd_accept;
    logic              hit;
    logic [LINE_W-1:0] hit_line;
    logic [31:0]       hit_word;
    logic [PTR_W-1:0]  idx;

    assign empty     = (count == 3'd0);
    assign full      = (count == 3'(DEPTH));
    assign wb_ready  = !full;
    assign rd_ready  = (state == IDLE);
    assign push      = wb_valid && wb_ready;
    assign pop       = (state == WR_REQ) && done;
    assign rd_accept = rd_req && rd_ready;

    // Scan oldest to youngest so the last match wins; a line arriving this cycle is youngest of all.
    always_comb begin
        hit      = 1'b0;
        hit_line = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((3'(i) < count) && (line_addr[idx] == rd_addr[ADDR_W-1:4])) begin
                hit      = 1'b1;
                hit_line = line_data[idx];
            end
        end
        if (push && (wb_addr[ADDR_W-1:4] == rd_addr[ADDR_W-1:4])) begin
            hit      = 1'b1;
            hit_line = wb_data;
        end
    end

    assign hit_word = hit_line[{rd_addr[3:2], 5'b00000} +: 32];

    always_ff @(posedge clk) begin
        if (push) begin
            line_addr[wr_ptr] <= wb_addr[ADDR_W-1:4];
            line_data[wr_ptr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= 3'd0;
            write    <= 1'b0;
            w_burst  <= 3'd0;
            addr_wr  <= '0;
            data_wr  <= '0;
            read     <= 1'b0;
            r_burst  <= 3'd0;
            addr_rd  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= 32'd0;
        end else begin
            rd_valid <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 3'd1;
            else if (pop && !push)
                count <= count - 3'd1;

            case (state)
                IDLE: begin
                    if (rd_accept) begin
                        if (hit) begin
                            rd_valid <= 1'b1;
                            rd_data  <= hit_word;
                        end else begin
                            state   <= RD_REQ;
                            read    <= 1'b1;
                            r_burst <= 3'd1;
                            addr_rd <= {rd_addr[ADDR_W-1:2], 2'b00};
                        end
                    end else if (!empty) begin
                        state   <= WR_REQ;
                        write   <= 1'b1;
                        w_burst <= 3'd4;
                        addr_wr <= {line_addr[rd_ptr], 4'b0000};
                        data_wr <= line_data[rd_ptr];
                    end
                end
                WR_REQ: begin
                    if (done) begin
                        state   <= WR_GAP;
                        write   <= 1'b0;
                        w_burst <= 3'd0;
                    end
                end
                // The master needs write low for a cycle before it sees the next request.
                WR_GAP: state <= IDLE;
                RD_REQ: begin
                    if (done_r) begin
                        state    <= RD_GAP;
                        read     <= 1'b0;
                        r_burst  <= 3'd0;
                        rd_data  <= data_rd;
                        rd_valid <= 1'b1;
                    end
                end
                RD_GAP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_buffer.sv
// Randomized bench for axi_write_buffer: a queue-based model of the buffered lines predicts
// counts, drained bursts and read results, with directed cases for the main scenarios.
module tb_axi_write_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wb_valid = 1'b0;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr = '0;
    logic [LINE_W-1:0] wb_data = '0;
    logic              rd_req = 1'b0;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic [2:0]        count;
    logic              empty;
    logic              full;
    logic              write;
    logic [ADDR_W-1:0] addr_wr;
    logic [LINE_W-1:0] data_wr;
    logic [2:0]        w_burst;
    logic              done = 1'b0;
    logic              read;
    logic [ADDR_W-1:0] addr_rd;
    logic [2:0]        r_burst;
    logic              done_r = 1'b0;
    logic [31:0]       data_rd = '0;

    always #5 clk = ~clk;

    axi_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .count(count), .empty(empty), .full(full),
        .write(write), .addr_wr(addr_wr), .data_wr(data_wr), .w_burst(w_burst), .done(done),
        .read(read), .addr_rd(addr_rd), .r_burst(r_burst), .done_r(done_r), .data_rd(data_rd)
    );

    typedef struct {
        logic [3:0]   la;
        logic [127:0] data;
    } line_t;

    line_t       q[$];
    int          total = 0;
    int          bad = 0;
    bit          expRdValid = 0;
    logic [31:0] expRdData = '0;
    bit          readPending = 0;
    logic [7:0]  expAddrRd = '0;
    bit          lastPop = 0;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Everything observable after an edge, judged against the model queue and pending transactions.
    task automatic checkCycle();
        checkOutput("count", count, q.size());
        checkOutput("empty", empty, q.size() == 0);
        checkOutput("full", full, q.size() == DEPTH);
        checkOutput("wb_ready", wb_ready, q.size() != DEPTH);
        checkOutput("rd_valid", rd_valid, expRdValid);
        if (expRdValid) checkOutput("rd_data", rd_data, expRdData);
        checkOutput("read", read, readPending);
        if (readPending) begin
            checkOutput("addr_rd", addr_rd, expAddrRd);
            checkOutput("r_burst", r_burst, 3'd1);
        end else begin
            checkOutput("r_burst_idle", r_burst, 3'd0);
        end
        if (lastPop) checkOutput("wr_gap", write, 1'b0);
        if (write) begin
            checkOutput("wr_has_head", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
                checkOutput("addr_wr", addr_wr, {q[0].la, 4'b0000});
                checkOutput("data_wr", data_wr, q[0].data);
            end
            checkOutput("w_burst", w_burst, 3'd4);
        end else begin
            checkOutput("w_burst_idle", w_burst, 3'd0);
        end
        if (rd_ready) checkOutput("rd_ready_busy", write || read, 1'b0);
    endtask

    // One clock: drive inputs, predict the effect of the edge, then check after it.
    task automatic applyStimulus(input bit wv, input logic [7:0] wa, input logic [127:0] wd,
                                 input bit rq, input logic [7:0] ra,
                                 input bit dn, input bit dnr, input logic [31:0] drd);
        bit           push;
        bit           nextValid;
        bit           found;
        logic [127:0] ln;
        line_t        e;
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        rd_req = rq; rd_addr = ra;
        done = dn; done_r = dnr; data_rd = drd;
        push      = wv && (q.size() < DEPTH);
        nextValid = 0;
        found     = 0;
        ln        = '0;
        lastPop   = 0;
        if (rq && rd_ready) begin
            foreach (q[i]) begin
                if (q[i].la == ra[7:4]) begin
                    found = 1;
                    ln = q[i].data;
                end
            end
            if (push && wa[7:4] == ra[7:4]) begin
                found = 1;
                ln = wd;
            end
            if (found) begin
                nextValid = 1;
                expRdData = ln[32*ra[3:2] +: 32];
            end else begin
                readPending = 1;
                expAddrRd = {ra[7:2], 2'b00};
            end
        end
        if (dn && write && q.size() != 0) begin
            void'(q.pop_front());
            lastPop = 1;
        end
        if (dnr && read) begin
            nextValid = 1;
            expRdData = drd;
            readPending = 0;
        end
        if (push) begin
            e.la = wa[7:4];
            e.data = wd;
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        expRdValid = nextValid;
        checkCycle();
    endtask

    task automatic idle();
        applyStimulus(0, 8'h00, '0, 0, 8'h00, 0, 0, 32'h0);
    endtask

    task automatic doReset(input int n);
        reset = 0; wb_valid = 0; rd_req = 0; done = 0; done_r = 0;
        q.delete();
        readPending = 0;
        expRdValid = 0;
        lastPop = 0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("rst_write", write, 1'b0);
        checkOutput("rst_read", read, 1'b0);
        checkOutput("rst_w_burst", w_burst, 3'd0);
        checkOutput("rst_r_burst", r_burst, 3'd0);
        checkOutput("rst_addr_wr", addr_wr, 8'h00);
        checkOutput("rst_addr_rd", addr_rd, 8'h00);
        checkOutput("rst_data_wr", data_wr, 128'h0);
        checkOutput("rst_rd_valid", rd_valid, 1'b0);
        checkOutput("rst_rd_data", rd_data, 32'h0);
        checkOutput("rst_count", count, 3'd0);
        checkOutput("rst_empty", empty, 1'b1);
        checkOutput("rst_full", full, 1'b0);
        reset = 1;
    endtask

    // Answer every outstanding request until the model queue is empty, within a cycle budget.
    task automatic drainAll();
        int n = 0;
        while ((q.size() != 0 || readPending) && n < 200) begin
            applyStimulus(0, 8'h00, '0, 0, 8'h00, write, read, $urandom);
            n++;
        end
        checkOutput("drain_budget", q.size(), 0);
        idle();
        idle();
    endtask

    initial begin
        logic [127:0] d1;
        logic [127:0] lineA;
        logic [127:0] lineB;
        bit           wv, rq, dn, dnr;
        logic [7:0]   wa, ra;
        logic [127:0] wd;

        d1    = 128'habcd1010efef11112222222233333333;
        lineA = {96'h0, 32'h000000AA};
        lineB = {96'h1, 32'h000000BB};

        @(negedge clk);
        doReset(2);
        checkOutput("rst_rd_ready", rd_ready, 1'b1);

        // Buffered line forwards a word without touching the master, then drains as a burst.
        applyStimulus(1, 8'h04, d1, 0, 8'h00, 0, 0, 32'h0);
        applyStimulus(0, 8'h00, '0, 1, 8'h04, 0, 0, 32'h0);
        checkOutput("fwd_rd_valid", rd_valid, 1'b1);
        checkOutput("fwd_rd_data", rd_data, 32'h22222222);
        checkOutput("fwd_read", read, 1'b0);
        idle();
        checkOutput("wb_write", write, 1'b1);
        checkOutput("wb_addr_wr", addr_wr, 8'h00);
        checkOutput("wb_w_burst", w_burst, 3'd4);
        checkOutput("wb_count", count, 3'd1);
        idle();
        idle();
        applyStimulus(0, 8'h00, '0, 0, 8'h00, 1, 0, 32'h0);
        checkOutput("wb_done_count", count, 3'd0);
        checkOutput("wb_done_write", write, 1'b0);
        idle();
        idle();

        // Two copies of one line: the youngest supplies the word, same-cycle push included.
        applyStimulus(1, 8'h10, lineA, 0, 8'h00, 0, 0, 32'h0);
        applyStimulus(1, 8'h10, lineB, 1, 8'h10, 0, 0, 32'h0);
        checkOutput("young_push_data", rd_data, 32'h000000BB);
        applyStimulus(0, 8'h00, '0, 1, 8'h10, 0, 0, 32'h0);
        checkOutput("young_fifo_data", rd_data, 32'h000000BB);
        drainAll();

        // Fill to capacity with the master stalled, then drain in order.
        for (int i = 0; i < DEPTH + 1; i++)
            applyStimulus(1, 8'(8'h20 + 16 * i), {$urandom, $urandom, $urandom, $urandom},
                          0, 8'h00, 0, 0, 32'h0);
        checkOutput("fill_full", full, 1'b1);
        checkOutput("fill_wb_ready", wb_ready, 1'b0);
        checkOutput("fill_count", count, 3'd4);
        drainAll();

        // Miss goes to the master as a single-beat read.
        applyStimulus(0, 8'h00, '0, 1, 8'h24, 0, 0, 32'h0);
        checkOutput("miss_read", read, 1'b1);
        checkOutput("miss_addr_rd", addr_rd, 8'h24);
        checkOutput("miss_r_burst", r_burst, 3'd1);
        idle();
        idle();
        applyStimulus(0, 8'h00, '0, 0, 8'h00, 0, 1, 32'hDEADBEEF);
        checkOutput("miss_rd_valid", rd_valid, 1'b1);
        checkOutput("miss_rd_data", rd_data, 32'hDEADBEEF);
        idle();

        // Reset in the middle of a burst drops it; a late done must not disturb the empty buffer.
        applyStimulus(1, 8'h60, {$urandom, $urandom, $urandom, $urandom}, 0, 8'h00, 0, 0, 32'h0);
        idle();
        checkOutput("mid_write", write, 1'b1);
        doReset(1);
        applyStimulus(0, 8'h00, '0, 0, 8'h00, 1, 0, 32'h0);
        checkOutput("stale_count", count, 3'd0);
        checkOutput("stale_write", write, 1'b0);
        idle();

        for (int c = 0; c < 1500; c++) begin
            wv  = ($urandom % 3 == 0);
            wa  = {4'($urandom_range(0, 3)), 4'($urandom)};
            wd  = {$urandom, $urandom, $urandom, $urandom};
            rq  = ($urandom % 3 == 0);
            ra  = {4'($urandom_range(0, 4)), 4'($urandom)};
            dn  = write ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
            dnr = read ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
            applyStimulus(wv, wa, wd, rq, ra, dn, dnr, $urandom);
        end
        drainAll();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
